// File: rtl/gates4a_sweep_ctrl.sv
// gates4a_sweep_ctrl
//
// Sweep/self-test controller for the 4-input reduction-gate unit. On start it
// walks the operand a_out through 0..15. It holds each operand for
// SETTLE_CYCLES cycles and then compares y_in against a golden model for one
// cycle. Errors are accumulated, and the first failing operand and result are
// kept. In single-step mode the controller pauses after each compare until a
// step pulse arrives.
//
// Handshake: start and step are single-cycle pulses. No ready/valid pair
// exists. start is accepted only in IDLE or DONE. step is accepted only in
// WAIT_STEP. Pulses in any other state are dropped.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start        begin a sweep (IDLE/DONE only)
//   step_mode    1 = pause in WAIT_STEP after each compare (sampled in COMPARE)
//   step         advance to the next pattern from WAIT_STEP
//   y_in[5:0]    gate unit result {xnor, xor, nor, or, nand, and}
//   a_out[3:0]   operand driven to the gate unit
//   busy         high in SETTLE, COMPARE, WAIT_STEP
//   done         high in DONE
//   pass         high in DONE when no pattern mismatched
//   err_count    mismatching patterns this sweep (0..16)
//   err_bits     sticky OR of y_in ^ golden over all mismatches
//   first_err_a  operand of the first mismatch
//   first_err_y  y_in captured at the first mismatch
//   state_dbg    current FSM state, for observation only

module gates4a_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       step_mode,
    input  logic       step,
    input  logic [5:0] y_in,
    output logic [3:0] a_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [5:0] err_bits,
    output logic [3:0] first_err_a,
    output logic [5:0] first_err_y,
    output logic [2:0] state_dbg
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SETTLE    = 3'd1;
    localparam logic [2:0] S_COMPARE   = 3'd2;
    localparam logic [2:0] S_WAIT_STEP = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    logic [2:0] state;
    logic [3:0] settle_cnt;
    logic [5:0] golden;
    logic [5:0] diff;

    assign golden = {~^a_out, ^a_out, ~|a_out, |a_out, ~&a_out, &a_out};
    assign diff   = y_in ^ golden;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            settle_cnt  <= '0;
            a_out       <= '0;
            err_count   <= '0;
            err_bits    <= '0;
            first_err_a <= '0;
            first_err_y <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        err_count   <= '0;
                        err_bits    <= '0;
                        first_err_a <= '0;
                        first_err_y <= '0;
                        a_out       <= '0;
                        settle_cnt  <= SETTLE_LOAD;
                        state       <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    // The counter is loaded with SETTLE_CYCLES on entry.
                    // The transition happens on the cycle where it reads 1,
                    // which gives exactly SETTLE_CYCLES cycles in SETTLE.
                    if (settle_cnt <= 4'd1) begin
                        state <= S_COMPARE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                S_COMPARE: begin
                    if (diff != 6'd0) begin
                        err_count <= err_count + 5'd1;
                        err_bits  <= err_bits | diff;
                        if (err_count == 5'd0) begin
                            first_err_a <= a_out;
                            first_err_y <= y_in;
                        end
                    end
                    if (a_out == 4'd15) begin
                        state <= S_DONE;
                    end else if (step_mode) begin
                        state <= S_WAIT_STEP;
                    end else begin
                        a_out      <= a_out + 4'd1;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= S_SETTLE;
                    end
                end
                S_WAIT_STEP: begin
                    if (step) begin
                        a_out      <= a_out + 4'd1;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= S_SETTLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state == S_SETTLE) || (state == S_COMPARE) || (state == S_WAIT_STEP);
    assign done      = (state == S_DONE);
    // err_count is already frozen in DONE, so pass is a pure decode.
    assign pass      = done && (err_count == 5'd0);
    assign state_dbg = state;

endmodule

// File: tb/tb_gates4a_sweep_ctrl.sv
// Testbench for gates4a_sweep_ctrl. Three instances, with settle times 1, 3
// and 15, share clock and reset. A behavioural gate unit answers each
// instance. A per-operand XOR table injects faults into that unit. Expected
// sweep results come from walking the fault table directly.

module tb_gates4a_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start[3];
    logic       step[3];
    logic       step_mode[3];
    logic [5:0] y_in[3];
    logic [3:0] a_out[3];
    logic       busy[3];
    logic       done[3];
    logic       pass[3];
    logic [4:0] err_count[3];
    logic [5:0] err_bits[3];
    logic [3:0] first_err_a[3];
    logic [5:0] first_err_y[3];
    logic [2:0] state_dbg[3];

    logic [5:0] fault_tab[16];
    logic [3:0] exp_q[$];
    bit         perturb = 1'b0;
    int         cyc = 0;
    int         t0 = 0;
    int         n_checks = 0;
    int         n_pass = 0;

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        gates4a_sweep_ctrl #(.SETTLE_CYCLES((gi == 0) ? 1 : (gi == 1) ? 3 : 15)) u_dut (
            .clk(clk), .rst(rst), .start(start[gi]), .step_mode(step_mode[gi]),
            .step(step[gi]), .y_in(y_in[gi]), .a_out(a_out[gi]), .busy(busy[gi]),
            .done(done[gi]), .pass(pass[gi]), .err_count(err_count[gi]),
            .err_bits(err_bits[gi]), .first_err_a(first_err_a[gi]),
            .first_err_y(first_err_y[gi]), .state_dbg(state_dbg[gi])
        );
    end

    function automatic logic [5:0] golden(input logic [3:0] a);
        int ones;
        ones = a[0] + a[1] + a[2] + a[3];
        return {ones % 2 == 0, ones % 2 == 1, ones == 0, ones != 0, ones != 4, ones == 4};
    endfunction

    // Gate unit model. Instance 2 can receive garbage on every cycle except
    // the one ahead of a compare edge (edge k with k % 16 == 0 for S=15).
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            y_in[i] = golden(a_out[i]) ^ fault_tab[a_out[i]];
            if (perturb && i == 2 && ((cyc - t0 + 1) % 16) != 0)
                y_in[i] = 6'($urandom);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic pulse_start(input int i);
        @(negedge clk);
        start[i] = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        start[i] = 1'b0;
        check("restart_done", done[i], 0);
        check("restart_pass", pass[i], 0);
        check("restart_err", err_count[i], 0);
        check("restart_busy", busy[i], 1);
        check("restart_a", a_out[i], 0);
    endtask

    task automatic check_results(input int i);
        int cnt = 0;
        logic [5:0] bits = '0;
        logic [3:0] fa = '0;
        logic [5:0] fy = '0;
        for (int a = 0; a < 16; a++) begin
            if (fault_tab[a] != 6'd0) begin
                if (cnt == 0) begin
                    fa = 4'(a);
                    fy = golden(4'(a)) ^ fault_tab[a];
                end
                cnt++;
                bits |= fault_tab[a];
            end
        end
        check("err_count", err_count[i], cnt);
        check("err_bits", err_bits[i], bits);
        check("first_err_a", first_err_a[i], fa);
        check("first_err_y", first_err_y[i], fy);
        check("pass", pass[i], cnt == 0);
        check("a_out_end", a_out[i], 15);
        check("busy_end", busy[i], 0);
    endtask

    // Free-run sweep. With extras set, start pulses reach edges 5 and 20 and
    // random step pulses arrive. The controller must ignore all of them.
    task automatic run_free(input int i, input int s, input bit extras);
        int k = 0;
        bit seen = 0;
        step_mode[i] = 1'b0;
        pulse_start(i);
        for (int c = 0; c < 600 && !seen; c++) begin
            @(negedge clk);
            k = cyc - t0;
            if (done[i]) seen = 1;
            else begin
                start[i] = extras && (k + 1 == 5 || k + 1 == 20);
                step[i]  = extras && ($urandom_range(0, 3) == 0);
            end
        end
        start[i] = 1'b0;
        step[i]  = 1'b0;
        check("done_latency", seen ? k : -1, 16 * (s + 1));
        check_results(i);
    endtask

    task automatic run_step(input int i, input int s);
        step_mode[i] = 1'b1;
        for (int n = 0; n < 16; n++) exp_q.push_back(4'(n));
        pulse_start(i);
        for (int n = 0; n < 16; n++) begin
            logic [3:0] exp_a;
            repeat (s + 1) @(posedge clk);
            @(negedge clk);
            exp_a = exp_q.pop_front();
            if (n < 15) begin
                repeat (4) @(negedge clk);
                start[i] = 1'b1;
                @(negedge clk);
                start[i] = 1'b0;
                repeat (5) @(negedge clk);
                check("step_wait_a", a_out[i], exp_a);
                check("step_wait_busy", busy[i], 1);
                check("step_wait_done", done[i], 0);
                step[i] = 1'b1;
                @(posedge clk);
                #1;
                step[i] = 1'b0;
                check("step_adv_a", a_out[i], exp_a + 4'd1);
            end else begin
                check("step_done", done[i], 1);
                check("step_last_a", a_out[i], exp_a);
            end
        end
        step_mode[i] = 1'b0;
        check_results(i);
    endtask

    task automatic check_reset_vals(input int i);
        check("rst_a", a_out[i], 0);
        check("rst_busy", busy[i], 0);
        check("rst_done", done[i], 0);
        check("rst_pass", pass[i], 0);
        check("rst_err", err_count[i], 0);
        check("rst_bits", err_bits[i], 0);
        check("rst_fa", first_err_a[i], 0);
        check("rst_fy", first_err_y[i], 0);
    endtask

    initial begin
        bit hit;
        for (int i = 0; i < 3; i++) begin
            start[i] = 0;
            step[i] = 0;
            step_mode[i] = 0;
        end
        for (int a = 0; a < 16; a++) fault_tab[a] = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) check_reset_vals(i);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // ideal unit, S=1
        run_free(0, 1, 0);

        // y_in[4] stuck at 0: odd-parity operands fail
        for (int a = 0; a < 16; a++) fault_tab[a] = golden(4'(a)) & 6'b010000;
        run_free(0, 1, 0);

        // random faults, with ignored start/step pulses during the sweep
        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < 16; a++)
                fault_tab[a] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            run_free(0, 1, 1);
        end

        // single-step, S=3
        for (int a = 0; a < 16; a++)
            fault_tab[a] = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
        run_step(1, 3);

        // S=15, ideal unit with settle-time garbage
        for (int a = 0; a < 16; a++) fault_tab[a] = '0;
        perturb = 1'b1;
        run_free(2, 15, 0);
        perturb = 1'b0;

        // asynchronous reset mid-sweep at a_out=7 with two errors logged
        fault_tab[2] = 6'b000001;
        fault_tab[5] = 6'b100000;
        pulse_start(0);
        hit = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            if (a_out[0] == 4'd7) hit = 1;
        end
        check("mid_reached_a7", hit, 1);
        check("mid_err_count", err_count[0], 2);
        #2 rst = 1'b1;
        #1 check_reset_vals(0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("post_rst_busy", busy[0], 0);
        check("post_rst_a", a_out[0], 0);
        check("post_rst_done", done[0], 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
